// File: rtl/gray_counter_param.sv
// gray_counter_param: up/down Gray-code counter with load, sticky Overflow and one-cycle Limit pulse
// Define GRAY_CNT_SATURATE_EN to hold at the end values instead of wrapping.
module gray_counter_param #(
    parameter int WIDTH = 3,
    parameter int INIT  = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             Clr,
    output logic [WIDTH-1:0] Output,
    output logic             Overflow,
    output logic             Limit
);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
    logic [WIDTH-1:0] bin, step;
    logic wrap;
    always_comb begin
        wrap = En && !Load && (Dir ? bin == '0 : bin == '1);
`ifdef GRAY_CNT_SATURATE_EN
        step = wrap ? bin : Dir ? bin - WIDTH'(1) : bin + WIDTH'(1);
`else
        step = Dir ? bin - WIDTH'(1) : bin + WIDTH'(1);
`endif
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bin      <= INIT_V;
            Overflow <= 1'b0;
            Limit    <= 1'b0;
        end else begin
            bin      <= Load ? LoadVal : En ? step : bin;
            Limit    <= wrap;
            Overflow <= wrap | (Overflow & ~Clr);
        end
    end
    assign Output = bin ^ (bin >> 1);
endmodule
